// File: rtl/cory_wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin packet arbiter:
// lock FSM encoding and the source-index width helper.
package cory_wrr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Source index width: ceil(log2(r)), never narrower than one bit.
    function automatic int calc_s(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/cory_rr_pick.sv
// Rotating first-one finder: scans req_i starting at ptr_i, wrapping modulo R,
// and returns the first set position as a one-hot grant and as an index.
module cory_rr_pick #(
    parameter int R = 4,
    parameter int S = 2
) (
    input  logic [R-1:0] req_i,
    input  logic [S-1:0] ptr_i,
    output logic [R-1:0] gnt_o,
    output logic [S-1:0] idx_o,
    output logic         any_o
);

    logic [S-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < R; i++) begin
            cand = S'((int'(ptr_i) + i) % R);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cory_wrr_arb.sv
// Weighted round-robin arbiter with packet lock and a registered output stage.
// Optional per-port completed-packet counters when CORY_WRR_ARB_STAT_EN is defined.
module cory_wrr_arb
    import cory_wrr_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4,
    parameter int W = 4,
    localparam int S = calc_s(R)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [R-1:0]     i_ax_v,
    input  logic [R*N-1:0]   i_ax_d,
    input  logic [R-1:0]     i_ax_l,
    output logic [R-1:0]     o_ax_r,
    output logic             o_z_v,
    output logic [N-1:0]     o_z_d,
    output logic [S-1:0]     o_z_s,
    output logic             o_z_l,
    input  logic             i_z_r,
`ifdef CORY_WRR_ARB_STAT_EN
    input  logic             i_stat_clr,
    output logic [R*16-1:0]  o_pkt_cnt,
`endif
    input  logic [R*W-1:0]   i_wgt
);

    state_e              state_q, state_d;
    logic [S-1:0]        ptr_q, ptr_d;
    logic [S-1:0]        lock_q, lock_d;
    logic [R-1:0][W-1:0] cred_q, cred_d, cred_eff;

    logic                z_v_q;
    logic [N-1:0]        z_d_q;
    logic [S-1:0]        z_s_q;
    logic                z_l_q;

    logic [R-1:0]        has_cred, elig, win_oh, lock_oh;
    logic [S-1:0]        win_idx, sel_idx;
    logic                win_any, reload, load;
    logic                accept, acc_l, done;
    logic [N-1:0]        acc_d;
    logic [W-1:0]        rem;

    // Credits are refilled in the same cycle nobody valid has any left, so
    // the grant below already sees the reloaded values.
    always_comb begin
        has_cred = '0;
        elig     = '0;
        cred_eff = cred_q;
        for (int k = 0; k < R; k++) begin
            has_cred[k] = i_ax_v[k] && (cred_q[k] != '0);
        end
        reload = (state_q == IDLE) && (|i_ax_v) && !(|has_cred);
        for (int k = 0; k < R; k++) begin
            if (reload) begin
                cred_eff[k] = (i_wgt[k*W +: W] == '0) ? W'(1) : i_wgt[k*W +: W];
            end
            elig[k] = i_ax_v[k] && (cred_eff[k] != '0);
        end
    end

    cory_rr_pick #(
        .R (R),
        .S (S)
    ) u_pick (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign load    = !z_v_q || i_z_r;
    assign lock_oh = R'(1) << lock_q;
    assign sel_idx = (state_q == LOCK) ? lock_q : win_idx;
    assign accept  = |(i_ax_v & o_ax_r);
    assign acc_l   = i_ax_l[sel_idx];
    assign acc_d   = i_ax_d[sel_idx*N +: N];
    assign done    = accept && acc_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (accept && !acc_l) begin
                    state_d = LOCK;
                    lock_d  = win_idx;
                end
            end
            LOCK: begin
                if (accept && acc_l) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ax_r = '0;
        if (load) begin
            if (state_q == LOCK) begin
                o_ax_r = lock_oh;
            end else if (win_any) begin
                o_ax_r = win_oh;
            end
        end
    end

    // A port keeps priority while it still holds credit after its packet.
    always_comb begin
        cred_d = cred_eff;
        ptr_d  = ptr_q;
        if ((state_q == IDLE) && accept && (cred_eff[win_idx] != '0)) begin
            cred_d[win_idx] = cred_eff[win_idx] - W'(1);
        end
        rem = (state_q == IDLE) ? cred_d[win_idx] : cred_q[lock_q];
        if (done) begin
            if (rem != '0) begin
                ptr_d = sel_idx;
            end else begin
                ptr_d = (sel_idx == S'(R-1)) ? '0 : sel_idx + S'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            cred_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cred_q <= cred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_v_q <= 1'b0;
            z_d_q <= '0;
            z_s_q <= '0;
            z_l_q <= 1'b0;
        end else if (load) begin
            z_v_q <= accept;
            if (accept) begin
                z_d_q <= acc_d;
                z_s_q <= sel_idx;
                z_l_q <= acc_l;
            end
        end
    end

    assign o_z_v = z_v_q;
    assign o_z_d = z_d_q;
    assign o_z_s = z_s_q;
    assign o_z_l = z_l_q;

`ifdef CORY_WRR_ARB_STAT_EN
    logic [R-1:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || i_stat_clr) begin
            cnt_q <= '0;
        end else if (done) begin
            cnt_q[sel_idx] <= cnt_q[sel_idx] + 16'd1;
        end
    end

    assign o_pkt_cnt = cnt_q;
`endif

endmodule

// File: doc/cory_wrr_arb.md
Name: cory_wrr_arb

Overview:
- Weighted round-robin arbiter with packet lock.
- Shares one valid/ready output stream between R valid/ready requester streams.
- Each requester gets up to its programmed weight in packets per round; a packet, delimited by a last flag, is never interleaved.
- Sits where a plain round-robin arbiter would, when requesters need unequal bandwidth and multi-beat packets must stay contiguous. The output is registered.

Parameters:
- N, 8, data bits per beat
- R, 4, number of requesters, 2..16
- W, 4, weight field width per requester
- S, derived = ceil(log2(R)), min 1, width of source index

Ports:
- clk  input  1  clock
- reset  input  1  reset
- i_ax_v  input  R  requester valid, bit k = port k
- i_ax_d  input  R*N  requester data, slice k*N +: N = port k
- i_ax_l  input  R  requester last-beat flag
- o_ax_r  output  R  requester ready, at most one bit set
- o_z_v  output  1  output valid
- o_z_d  output  N  output data
- o_z_s  output  S  source port index of current output beat
- o_z_l  output  1  output last flag
- i_z_r  input  1  output ready
- i_wgt  input  R*W  packet weight per port; 0 treated as 1

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - o_z_v=0, o_z_d=0, o_z_s=0, o_z_l=0, o_ax_r=0.
  - State IDLE, rotate pointer ptr=0, all credits=0.
- Output register:
  - load = !o_z_v || i_z_r.
  - An input beat accepted (i_ax_v[k] && o_ax_r[k]) appears on o_z_* the next cycle. Latency 1, full throughput.
  - o_z_v drops only when i_z_r && no new beat is accepted.
  - o_z_* hold stable while o_z_v && !i_z_r.
- State IDLE (no packet open):
  - Eligible port = valid with credit > 0.
  - If no valid port has credit, every credit is reloaded from i_wgt in the same cycle and eligibility is recomputed. Reload is combinational, so there is no bubble.
  - Winner = first eligible port scanning ptr, ptr+1, ... wrapping modulo R.
  - o_ax_r[winner] = load. No ready is asserted if no valid port exists or load=0.
- On accepting the winner's first beat:
  - credit[winner] decrements by 1.
  - If i_ax_l=0, enter LOCK with lock port = winner.
  - If i_ax_l=1, the packet is done; stay in IDLE.
- State LOCK:
  - o_ax_r[lock] = load, independent of i_ax_v.
  - All other readies are 0.
  - Leave to IDLE when a beat with i_ax_l=1 from the lock port is accepted.
- Pointer update on packet completion:
  - If the winner's remaining credit is 0, ptr = winner+1 (wrap to 0 after R-1).
  - Otherwise ptr = winner, so the same port keeps priority while it holds credit.
- Credit counters are W bits and never underflow; decrement only applies when credit > 0.
- i_wgt is sampled only at reload; a change mid-round takes effect at the next reload.
- Simultaneous events:
  - Completion and new-packet grant cannot occur in the same cycle, since the grant is decided from IDLE only.
  - A single-beat packet (l=1 on the first beat) completes in the same cycle it is granted.
- A requester that drops valid while not granted loses nothing; its credit is kept until the next reload.
- Reset asserted mid-packet:
  - Aborts the lock and clears the output register, ptr and credits.
  - The partial packet is not completed.

Optional Feature:
- Macro CORY_WRR_ARB_STAT_EN.
- Defined:
  - Adds output port o_pkt_cnt, width R*16: one 16-bit per-port count of completed packets (last beat accepted).
  - Counters wrap at 0xFFFF and are cleared by reset.
  - Adds input i_stat_clr, which clears all counters in one cycle; clear wins over a simultaneous increment.
- Not defined: neither port exists and no counter logic is built. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared package/header: state encoding (IDLE=0, LOCK=1) and the S-from-R width function.
- One natural sub-module, cory_rr_pick: combinational rotating first-one finder (request vector, start pointer -> one-hot grant plus index). It is reused for eligibility scan.
- Credits, lock FSM and output register stay in the top module.

Test Plan:
- Reset, then all valid with single-beat packets, i_wgt={1,1,1,1}, i_z_r=1 -> o_z_s sequence 0,1,2,3,0 on consecutive cycles; o_z_v first high 1 cycle after first accept.
- R=2, i_wgt port0=3, port1=1, both continuously valid, single-beat -> o_z_s pattern 0,0,0,1 repeating.
- Port0 sends a 4-beat packet (l on beat 4) while port1 is valid -> o_ax_r[1]=0 until port0's 4th beat is accepted; output beats 0..3 all show o_z_s=0 and contiguous data.
- i_z_r held 0 for 5 cycles with o_z_v=1 -> o_z_d/o_z_s/o_z_l stable, o_ax_r all 0; on release, one beat per cycle with no loss or duplication.
- Reset pulsed during LOCK at beat 2 -> next cycle o_z_v=0, state IDLE, port 0 arbitrated fresh with reloaded credits.
- With CORY_WRR_ARB_STAT_EN: 3 packets from port2 -> o_pkt_cnt slice 2 = 3; i_stat_clr same cycle as 4th completion -> count 0.
